// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, B folded at fetch, HALT stops fetch,
// execute redirects flush the buffer and restart. Fetched words reach decode through a small FIFO.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    // state  | meaning
    // FETCH  | no request; raise one as soon as the FIFO has room
    // WAIT   | request outstanding (possibly one being squashed)
    // HALTED | HALT fetched; only a redirect or reset restarts fetching
    typedef enum logic [1:0] {FETCH, WAIT, HALTED} state_t;

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, addr_nxt, br_tgt, imm_ext;
    logic              squash, squash_nxt, req_nxt, halted_nxt;
    logic              done, keep, push, pop, is_b, is_halt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];

    assign done    = imem_req & imem_ack;
    // A word returned on a redirect edge, or while squashing, is dropped undecoded.
    assign keep    = done & ~squash & ~redirect_valid;
    assign is_b    = (imem_rdata[31:25] == 7'b1100000);
    assign is_halt = (imem_rdata[31:30] == 2'b11) & imem_rdata[28] & ~imem_rdata[27];
    assign imm_ext = ADDR_W'($signed(imem_rdata[15:0]));
    assign br_tgt  = imem_addr + imm_ext;

    assign push      = keep;
    assign pop       = if_valid & id_ready & ~redirect_valid;
    assign count_nxt = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);

    assign if_valid = (count != '0);
    assign if_instr = fifo_instr[rd_ptr];
    assign if_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            squash    <= squash_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            halted    <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // FIFO is empty after the flush, so a request always follows (or keeps waiting to squash).
            state_nxt = WAIT;
        end else begin
            case (state)
                FETCH:   if (count_nxt < FULL) state_nxt = WAIT;
                WAIT: begin
                    if (done) begin
                        if (keep && is_halt)        state_nxt = HALTED;
                        else if (count_nxt < FULL)  state_nxt = WAIT;
                        else                        state_nxt = FETCH;
                    end
                end
                HALTED:  state_nxt = HALTED;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect_valid)
            pc_nxt = redirect_pc;
        else if (keep)
            pc_nxt = is_b ? br_tgt : imem_addr + ADDR_W'(1);
        squash_nxt = redirect_valid ? (imem_req & ~imem_ack) : (done ? 1'b0 : squash);
    end

    always_comb begin
        req_nxt    = (state_nxt == WAIT);
        addr_nxt   = (imem_req & ~imem_ack) ? imem_addr : pc_nxt;
        halted_nxt = (state_nxt == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            count <= count_nxt;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= imem_addr;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency memory, random backpressure and redirects, checked
// against an architectural program-order model (pc sequence with B/HALT/redirect rules).
module tb_instr_fetch;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    logic [31:0] imem [0:65535];
    int          n_chk = 0;
    int          n_err = 0;
    int          lat_min, lat_max, mem_lat;
    bit          mem_busy;
    logic [15:0] exp_pc;
    bit          stop;
    bit          pr_req, pr_ack, pr_redir;
    logic [15:0] pr_addr, pr_rpc;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_seq();
        for (int a = 0; a < 65536; a++) imem[a] = {16'h0F00, 16'(a)};
    endtask

    task automatic fill_rand();
        int r;
        logic [15:0] imm;
        for (int a = 0; a < 65536; a++) begin
            r = $urandom_range(0, 31);
            imm = 16'($urandom_range(0, 16)) - 16'd8;
            if (r < 4)       imem[a] = {7'b1100000, 9'($urandom), imm};
            else if (r == 31) imem[a] = {5'b11010, 27'($urandom)};
            else             imem[a] = {2'b00, 30'($urandom)};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        chk_eq("rst_req", imem_req, 0);
        chk_eq("rst_addr", imem_addr, 0);
        chk_eq("rst_valid", if_valid, 0);
        chk_eq("rst_instr", if_instr, 0);
        chk_eq("rst_pc", if_pc, 0);
        chk_eq("rst_halted", halted, 0);
        rst_n = 1'b1;
        exp_pc = 16'h0000; stop = 1'b0; mem_busy = 1'b0;
        pr_req = 1'b0; pr_ack = 1'b0; pr_redir = 1'b0; pr_addr = '0; pr_rpc = '0;
    endtask

    // Called at a negedge: check what the previous edge did, drive inputs, advance model, wait.
    task automatic step(input bit rdy, input bit redir, input logic [15:0] rpc);
        logic [31:0] w;
        if (pr_redir) begin
            chk_eq("flush_valid", if_valid, 0);
            chk_eq("redir_halted", halted, 0);
            chk_eq("redir_req", imem_req, 1);
            chk_eq("redir_addr", imem_addr, (pr_req && !pr_ack) ? pr_addr : pr_rpc);
        end else if (pr_req && !pr_ack) begin
            chk_eq("hold_req", imem_req, 1);
            chk_eq("hold_addr", imem_addr, pr_addr);
        end
        if (stop) begin
            chk_eq("halt_flag", halted, 1);
            chk_eq("halt_noreq", imem_req, 0);
        end

        id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_lat = $urandom_range(lat_max, lat_min);
            end
            imem_ack = (mem_lat == 0);
            imem_rdata = imem_ack ? imem[imem_addr] : $urandom;
            if (imem_ack) mem_busy = 1'b0;
            else          mem_lat--;
        end else begin
            mem_busy = 1'b0;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end

        if (redir) begin
            exp_pc = rpc;
            stop = 1'b0;
        end else if (if_valid && rdy) begin
            w = imem[exp_pc];
            chk_eq("deliver_pc", {stop, if_pc}, {1'b0, exp_pc});
            chk_eq("deliver_instr", if_instr, w);
            if (w[31:25] == 7'b1100000)                  exp_pc = exp_pc + w[15:0];
            else if (w[31:30] == 2'b11 && w[28] && !w[27]) stop = 1'b1;
            else                                           exp_pc = exp_pc + 16'd1;
        end
        pr_req = imem_req; pr_ack = imem_ack; pr_addr = imem_addr;
        pr_redir = redir; pr_rpc = rpc;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        lat_min = 0; lat_max = 0;

        // Backpressure, then sequential streaming
        fill_seq();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            if (i >= 2) chk_eq("bp_stable_pc", if_pc, 16'h0000);
        end
        chk_eq("bp_full_req", imem_req, 0);
        chk_eq("bp_head_valid", if_valid, 1);
        chk_eq("bp_head_instr", if_instr, 32'h0F00_0000);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk_eq("seq_req", imem_req, 1);
            chk_eq("seq_valid", if_valid, 1);
            step(1, 0, 0);
        end

        // Forward and backward unconditional branch at pc 4
        fill_seq(); imem[4] = 32'hC000_0010;
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        chk_eq("b_fwd_pc", if_pc, 16'h0019);
        fill_seq(); imem[4] = 32'hC000_FFFC;
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        chk_eq("b_back_pc", if_pc, 16'h0000);

        // HALT at pc 3, then redirect out of it
        fill_seq(); imem[3] = 32'hD000_0000;
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk_eq("halt_dir_flag", halted, 1);
        chk_eq("halt_dir_req", imem_req, 0);
        step(1, 1, 16'h0020);
        step(1, 0, 0);
        chk_eq("redir_lat_valid", if_valid, 1);
        chk_eq("redir_lat_pc", if_pc, 16'h0020);
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // Redirect while a slow request to pc 5 is outstanding
        fill_seq(); lat_min = 3; lat_max = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req && imem_addr == 16'h0005) found = 1'b1;
            else step(1, 0, 0);
        end
        chk_eq("sq_reach", {imem_req, imem_addr}, {1'b1, 16'h0005});
        step(1, 1, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            chk_eq("sq_hold_addr", imem_addr, 16'h0005);
            chk_eq("sq_empty", if_valid, 0);
            step(1, 0, 0);
        end
        chk_eq("sq_next_addr", {imem_req, imem_addr}, {1'b1, 16'h0040});
        chk_eq("sq_still_empty", if_valid, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0);

        // Asynchronous reset in the middle of a request
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else step(1, 0, 0);
        end
        chk_eq("ar_req_before", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("ar_req", imem_req, 0);
        chk_eq("ar_valid", if_valid, 0);
        lat_min = 0; lat_max = 0;
        do_reset();

        // PC wrap at the top of the address space
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 16'hFFFF);
        step(1, 0, 0);
        chk_eq("wrap_pc_top", {if_valid, if_pc}, {1'b1, 16'hFFFF});
        step(1, 0, 0);
        chk_eq("wrap_pc_zero", {if_valid, if_pc}, {1'b1, 16'h0000});
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // Randomized traffic
        fill_rand(); lat_min = 0; lat_max = 3;
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            for (int i = 0; i < 3000; i++) begin
                step(($urandom_range(0, 3) != 0),
                     stop ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0),
                     16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage, directly upstream of the instruction decode stage. Drives a word-addressed instruction-memory request/acknowledge port and buffers returned words with their PCs in a small FIFO. Presents them to decode through a valid/ready handshake.
Folds unconditional branches (B) at fetch. Stops fetching on HALT. Flushes and restarts when execute signals a redirect.

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width
RESET_PC, 0, PC value loaded at reset
DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  word address of the request
imem_ack  in  1  request completes this cycle; imem_rdata valid
imem_rdata  in  32  fetched instruction word
if_valid  out  1  FIFO head valid to decode
if_instr  out  32  FIFO head instruction
if_pc  out  ADDR_W  FIFO head PC
id_ready  in  1  decode accepts head this cycle
redirect_valid  in  1  execute-stage PC redirect (taken conditional branch, BR)
redirect_pc  in  ADDR_W  redirect target
halted  out  1  fetch stopped on HALT

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc=RESET_PC; FIFO empty.
  - imem_req=0; imem_addr=0.
  - if_valid=0; if_instr=0; if_pc=0.
  - halted=0; squash=0; state=FETCH.
- States:
  - FETCH: may issue requests.
  - WAIT: request outstanding.
  - HALTED: no requests.
- All outputs are registered, except if_instr, if_pc and if_valid, which are driven from the FIFO head storage.
- Memory protocol:
  - At most one request is outstanding.
  - In FETCH, imem_req rises when occupancy < DEPTH.
  - imem_addr=pc while imem_req is high.
  - imem_req and imem_addr are held stable until a cycle with imem_ack=1.
  - A request completes at the rising edge where imem_req=1 and imem_ack=1.
  - imem_ack with imem_req=0 is ignored.
  - A zero-wait memory (ack high in the first request cycle) sustains one fetch per cycle.
- On completion, unless squash=1:
  - Push {imem_addr, imem_rdata}.
  - If imem_rdata[31:25]==7'b1100000 (B): next pc = imem_addr + sign-extend(imem_rdata[15:0]), truncated to ADDR_W.
  - If imem_rdata[31:30]==2'b11, [28]=1 and [27]=0 (HALT): enter HALTED, halted=1, imem_req=0.
  - Otherwise: next pc = imem_addr+1, mod 2^ADDR_W (wraps to 0).
- FIFO:
  - Head is popped on a cycle with if_valid=1 and id_ready=1.
  - Push and pop in the same cycle are allowed.
  - Requests are gated so a completed push can never overflow: occupancy + outstanding <= DEPTH.
  - When the FIFO is full, imem_req stays 0.
  - if_instr and if_pc are held while if_valid=1 and id_ready=0.
- Redirect (highest priority; acts at the edge where redirect_valid=1):
  - FIFO is flushed; if_valid=0 next cycle. A same-cycle pop is discarded.
  - pc=redirect_pc.
  - halted=0 and state leaves HALTED. Redirect is the only exit from HALTED other than reset.
  - If a request is outstanding and not acked this edge, set squash=1.
  - If a request completes on this edge, its data is discarded and is not B/HALT-decoded.
- Squash:
  - imem_req stays high with the old address until ack.
  - That returned word is dropped and squash clears.
  - The request to redirect_pc is issued the next cycle.
- Reset asserted mid-request: outputs return to reset values immediately (imem_req=0); the pending transaction is abandoned.
- Latency: zero-wait memory, redirect at edge N -> imem_addr=redirect_pc at N+1 -> if_valid=1 with that word at N+2.

Test Plan:
- Sequential fetch: zero-wait memory with words = address, RESET_PC=0, id_ready=1 -> if_pc 0,1,2,3 on consecutive cycles; if_instr matches; imem_req continuous.
- Backpressure: id_ready=0 for 5 cycles after reset -> exactly 2 words buffered (pc 0,1); imem_req=0 while full; if_instr/if_pc stable; release -> 0,1,2 delivered in order, none lost or duplicated.
- Unconditional branch: word 0xC000_0010 at pc 4 -> B entry delivered with if_pc=4, next fetched pc=0x0014. Imm 0xFFFC at pc 4 -> next pc=0x0000.
- HALT: word 0xD000_0000 at pc 3 -> delivered, halted=1, no further imem_req. Redirect to 0x20 -> halted=0, next request addr 0x20.
- Redirect during wait-state fetch: 3-cycle ack latency, redirect_valid at cycle 1 of request to pc 5 with redirect_pc=0x40 -> imem_req held at 5 until ack, word for 5 never appears on if_*, next request 0x40, FIFO empty in between.
- Async reset mid-request and PC wrap: rst_n low with imem_req=1 -> imem_req=0 before next clk edge. Separately, fetch at pc 0xFFFF -> next pc 0x0000.
